axi4_master_bridge: RTL
=======================

Name: axi4_master_bridge

Overview:
- AXI4 initiator that turns a simple core-side request/response port into io_master_* AXI4 transactions toward the platform memory responder.
- Issues single-beat 32-bit writes and single-beat or INCR-burst 32-bit reads, with one transaction outstanding at a time.
- Sits between the CPU's fetch/load-store arbiter and the top-level io_master_* bus.

Parameters:
- AXI_ID, 4'h0, value driven on io_master_arid and io_master_awid.
- MAX_LEN, 8'd15, largest legal req_len (beats-1). A larger request is rejected locally with an error.

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-low reset (0 = in reset)
- req_valid  input  1  request valid
- req_ready  output  1  bridge idle and accepting a request
- req_write  input  1  1 = write, 0 = read
- req_addr  input  32  byte address
- req_wdata  input  32  write data
- req_wstrb  input  4  write byte strobes
- req_len  input  8  read beats minus 1 (ignored for writes)
- rsp_valid  output  1  one-cycle pulse per read beat, or once per write
- rsp_data  output  32  read data (0 for writes)
- rsp_last  output  1  last response of the transaction
- rsp_err  output  1  nonzero RRESP/BRESP, burst-length mismatch, or local reject
- io_master_aw*/w*/b*/ar*/r*  AXI4 master channels, with the same names and widths as the top-level io_master_* bus (awid/arid 4, addr 32, len 8, size 3, burst 2, wdata/rdata 32, wstrb 4, resp 2)

Behaviour:
- Reset (asynchronous, reset=0):
  - state = IDLE.
  - All valid/ready outputs are 0, except req_ready = 1.
  - rsp_* outputs are 0; internal counters and flags are cleared.
  - Reset asserted mid-transaction drops every valid immediately. There is no completion response.
- Constant outputs: size = 3'b010, burst = 2'b01 (INCR), awlen = 0, wlast = 1, IDs = AXI_ID.
- States: IDLE, RADDR, RDATA, WREQ, WRESP.
- IDLE:
  - req_ready = 1. A request is accepted on req_valid & req_ready.
  - On accept, the bridge latches addr, wdata, wstrb, len and write.
  - Write goes to WREQ. Read with req_len <= MAX_LEN goes to RADDR.
  - Read with req_len > MAX_LEN: no bus traffic; next cycle rsp_valid=1, rsp_err=1, rsp_last=1; stay in IDLE.
- RADDR: arvalid=1 with araddr/arlen from the latch. On arready, go to RDATA and clear beat_cnt.
- RDATA:
  - rready=1.
  - Each rvalid beat: next cycle rsp_valid=1, rsp_data=rdata, and rsp_err=(rresp!=0) for that beat.
  - beat_cnt increments per beat.
  - The transaction ends on rlast, or when beat_cnt == len, whichever comes first; it then returns to IDLE.
  - rsp_last=1 on the final response.
  - If rlast and (beat_cnt==len) disagree, the final response also has rsp_err=1.
- WREQ:
  - awvalid and wvalid are asserted in the same cycle. wvalid must never wait for awready or wready.
  - aw_done and w_done flags are set on the respective handshakes; each valid drops after its own handshake.
  - Handshakes may occur in either order or in the same cycle.
  - When both flags are set, go to WRESP.
- WRESP: bready=1. On bvalid: next cycle rsp_valid=1, rsp_last=1, rsp_data=0, rsp_err=(bresp!=0); return to IDLE.
- rsp_valid is registered: latency is 1 cycle after the R/B handshake, and it is never held for more than 1 cycle per beat.
- The consumer must accept every response pulse; there is no rsp backpressure.
- A new request is accepted no earlier than the cycle after the final rsp_valid. req_ready is 0 in all non-IDLE states.
- rid and bid are ignored.

Optional Feature:
- Macro: AXI_BRIDGE_ALIGN_CHECK_EN.
- Defined: a request with req_addr[1:0] != 0 issues no bus traffic. The next cycle it returns a single rsp_valid with rsp_err=1, rsp_last=1, rsp_data=0.
- Undefined: addresses are forwarded unmodified. Alignment is the responder's concern.

Test Plan:
- Single read: req addr=0x8000_0000, len=0; responder returns 0xDEADBEEF with rlast=1 -> araddr=0x8000_0000, arlen=0; one rsp_valid with data 0xDEADBEEF, rsp_last=1, rsp_err=0; req_ready back to 1.
- Burst read: len=3 at 0x8000_0010; responder returns 0x11, 0x22, 0x33, 0x44 with stalls on rvalid -> four rsp_valid pulses in order; rsp_last only on 0x44.
- Write ordering: addr=0xA000_03F8, wdata=0x41, wstrb=0001; responder asserts awready before wready, then the reverse, then both in the same cycle -> exactly one AW and one W handshake each time; one rsp_valid after B.
- Errors:
  - bresp=2'b10 -> rsp_err=1.
  - Burst len=3 with rlast on beat 2 -> 2 responses, the last with rsp_err=1, rsp_last=1.
  - req_len=16 -> local reject; no arvalid.
- Reset mid-burst: drive reset=0 after beat 1 of a len=3 read -> arvalid, rready and rsp_valid are 0 immediately; after release, req_ready=1 and a new read completes normally.
- With AXI_BRIDGE_ALIGN_CHECK_EN: read at 0x8000_0002 -> no arvalid; rsp_err=1 after 1 cycle. Without the macro: araddr=0x8000_0002 is issued.

Source files
------------

// File: rtl/axi4_master_bridge_if.sv
// -----------------------------------------------------------------------------
// axi4_master_bridge_if
//   AXI4 bus bundle between the core-side bridge and the platform responder.
//   Signal names and widths match the top-level io_master_* bus.
//
//   Channels:
//     AW : awvalid/awready, awid[3:0], awaddr[31:0], awlen[7:0], awsize[2:0],
//          awburst[1:0]
//     W  : wvalid/wready, wdata[31:0], wstrb[3:0], wlast
//     B  : bvalid/bready, bid[3:0], bresp[1:0]
//     AR : arvalid/arready, arid[3:0], araddr[31:0], arlen[7:0], arsize[2:0],
//          arburst[1:0]
//     R  : rvalid/rready, rid[3:0], rdata[31:0], rresp[1:0], rlast
//
//   Handshake rule for every channel: a transfer happens on a rising clock
//   edge where both valid and ready are 1. A source holds valid and payload
//   stable until that edge; a sink may raise or drop ready freely.
//
//   Modports: master (the bridge), slave (the memory responder).
// -----------------------------------------------------------------------------
interface axi4_master_bridge_if;
   logic        io_master_awvalid;
   logic        io_master_awready;
   logic [3:0]  io_master_awid;
   logic [31:0] io_master_awaddr;
   logic [7:0]  io_master_awlen;
   logic [2:0]  io_master_awsize;
   logic [1:0]  io_master_awburst;

   logic        io_master_wvalid;
   logic        io_master_wready;
   logic [31:0] io_master_wdata;
   logic [3:0]  io_master_wstrb;
   logic        io_master_wlast;

   logic        io_master_bvalid;
   logic        io_master_bready;
   logic [3:0]  io_master_bid;
   logic [1:0]  io_master_bresp;

   logic        io_master_arvalid;
   logic        io_master_arready;
   logic [3:0]  io_master_arid;
   logic [31:0] io_master_araddr;
   logic [7:0]  io_master_arlen;
   logic [2:0]  io_master_arsize;
   logic [1:0]  io_master_arburst;

   logic        io_master_rvalid;
   logic        io_master_rready;
   logic [3:0]  io_master_rid;
   logic [31:0] io_master_rdata;
   logic [1:0]  io_master_rresp;
   logic        io_master_rlast;

   modport master (
      output io_master_awvalid, io_master_awid, io_master_awaddr, io_master_awlen,
             io_master_awsize, io_master_awburst,
      input  io_master_awready,
      output io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
      input  io_master_wready,
      input  io_master_bvalid, io_master_bid, io_master_bresp,
      output io_master_bready,
      output io_master_arvalid, io_master_arid, io_master_araddr, io_master_arlen,
             io_master_arsize, io_master_arburst,
      input  io_master_arready,
      input  io_master_rvalid, io_master_rid, io_master_rdata, io_master_rresp,
             io_master_rlast,
      output io_master_rready
   );

   modport slave (
      input  io_master_awvalid, io_master_awid, io_master_awaddr, io_master_awlen,
             io_master_awsize, io_master_awburst,
      output io_master_awready,
      input  io_master_wvalid, io_master_wdata, io_master_wstrb, io_master_wlast,
      output io_master_wready,
      output io_master_bvalid, io_master_bid, io_master_bresp,
      input  io_master_bready,
      input  io_master_arvalid, io_master_arid, io_master_araddr, io_master_arlen,
             io_master_arsize, io_master_arburst,
      output io_master_arready,
      output io_master_rvalid, io_master_rid, io_master_rdata, io_master_rresp,
             io_master_rlast,
      input  io_master_rready
   );
endinterface

// File: rtl/axi4_master_bridge.sv
// -----------------------------------------------------------------------------
// axi4_master_bridge
//   Turns a simple core-side request/response port into AXI4 transactions:
//   single-beat 32-bit writes, single-beat or INCR-burst 32-bit reads, one
//   transaction outstanding at a time.
//
//   Optional feature macro: AXI_BRIDGE_ALIGN_CHECK_EN
//     defined   : requests with req_addr[1:0] != 0 are rejected locally with a
//                 single error response and no bus traffic.
//     undefined : addresses are forwarded unmodified.
//
//   Ports:
//     clock, reset (async, active-low)
//     req_valid/req_ready, req_write, req_addr, req_wdata, req_wstrb, req_len
//                 request port; req_len is read beats minus 1
//     rsp_valid, rsp_data, rsp_last, rsp_err
//                 one-cycle response pulse per read beat or per write; no
//                 backpressure, the consumer must take every pulse
//     dbg_state   current FSM state (IDLE=0 RADDR=1 RDATA=2 WREQ=3 WRESP=4)
//     bus         AXI4 master modport (io_master_*)
//
//   Request handshake: a request is taken on a rising edge with
//   req_valid & req_ready. req_ready is 1 only in IDLE, and drops for the
//   cycle in which the final rsp_valid pulse is shown.
// -----------------------------------------------------------------------------
module axi4_master_bridge #(
   parameter logic [3:0] AXI_ID  = 4'h0,
   parameter logic [7:0] MAX_LEN = 8'd15
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        req_valid,
   output logic                        req_ready,
   input  logic                        req_write,
   input  logic [31:0]                 req_addr,
   input  logic [31:0]                 req_wdata,
   input  logic [3:0]                  req_wstrb,
   input  logic [7:0]                  req_len,
   output logic                        rsp_valid,
   output logic [31:0]                 rsp_data,
   output logic                        rsp_last,
   output logic                        rsp_err,
   output logic [2:0]                  dbg_state,
   axi4_master_bridge_if.master        bus
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RADDR = 3'd1,
      RDATA = 3'd2,
      WREQ  = 3'd3,
      WRESP = 3'd4
   } state_t;

   state_t      state;

   logic        ar_valid;
   logic [31:0] ar_addr;
   logic [7:0]  ar_len;
   logic        r_ready;
   logic        aw_valid;
   logic [31:0] aw_addr;
   logic        w_valid;
   logic [31:0] w_data;
   logic [3:0]  w_strb;
   logic        b_ready;

   logic [7:0]  len_q;
   logic        write_q;
   logic [7:0]  beat_cnt;
   logic        aw_done;
   logic        w_done;

   // Constant AXI attributes: 4-byte beats, INCR bursts, single-beat writes.
   assign bus.io_master_awid    = AXI_ID;
   assign bus.io_master_arid    = AXI_ID;
   assign bus.io_master_awsize  = 3'b010;
   assign bus.io_master_arsize  = 3'b010;
   assign bus.io_master_awburst = 2'b01;
   assign bus.io_master_arburst = 2'b01;
   assign bus.io_master_awlen   = 8'd0;
   assign bus.io_master_wlast   = 1'b1;

   assign bus.io_master_arvalid = ar_valid;
   assign bus.io_master_araddr  = ar_addr;
   assign bus.io_master_arlen   = ar_len;
   assign bus.io_master_rready  = r_ready;
   assign bus.io_master_awvalid = aw_valid;
   assign bus.io_master_awaddr  = aw_addr;
   assign bus.io_master_wvalid  = w_valid;
   assign bus.io_master_wdata   = w_data;
   assign bus.io_master_wstrb   = w_strb;
   assign bus.io_master_bready  = b_ready;

   assign dbg_state = state;

   // Response IDs carry no information for a single-outstanding master.
   logic unused_ids;
   assign unused_ids = ^{bus.io_master_rid, bus.io_master_bid, write_q};

   logic misaligned;
`ifdef AXI_BRIDGE_ALIGN_CHECK_EN
   assign misaligned = (req_addr[1:0] != 2'b00);
`else
   assign misaligned = 1'b0;
`endif

   logic aw_hs;
   logic w_hs;
   logic cnt_hit;
   logic r_final;

   assign aw_hs   = aw_valid & bus.io_master_awready;
   assign w_hs    = w_valid & bus.io_master_wready;
   assign cnt_hit = (beat_cnt == len_q);
   // A burst ends on whichever comes first: responder's rlast or our count.
   assign r_final = bus.io_master_rlast | cnt_hit;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= 32'd0;
         rsp_last  <= 1'b0;
         rsp_err   <= 1'b0;
         ar_valid  <= 1'b0;
         ar_addr   <= 32'd0;
         ar_len    <= 8'd0;
         r_ready   <= 1'b0;
         aw_valid  <= 1'b0;
         aw_addr   <= 32'd0;
         w_valid   <= 1'b0;
         w_data    <= 32'd0;
         w_strb    <= 4'd0;
         b_ready   <= 1'b0;
         len_q     <= 8'd0;
         write_q   <= 1'b0;
         beat_cnt  <= 8'd0;
         aw_done   <= 1'b0;
         w_done    <= 1'b0;
      end else begin
         // Response outputs are single-cycle pulses.
         rsp_valid <= 1'b0;
         rsp_data  <= 32'd0;
         rsp_last  <= 1'b0;
         rsp_err   <= 1'b0;

         case (state)
            IDLE: begin
               if (!req_ready) begin
                  // This is the cycle showing the final response; reopen next.
                  req_ready <= 1'b1;
               end else if (req_valid) begin
                  req_ready <= 1'b0;
                  write_q   <= req_write;
                  len_q     <= req_len;
                  if (misaligned || (!req_write && (req_len > MAX_LEN))) begin
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_last  <= 1'b1;
                  end else if (req_write) begin
                     aw_addr  <= req_addr;
                     w_data   <= req_wdata;
                     w_strb   <= req_wstrb;
                     aw_valid <= 1'b1;
                     w_valid  <= 1'b1;
                     aw_done  <= 1'b0;
                     w_done   <= 1'b0;
                     state    <= WREQ;
                  end else begin
                     ar_addr  <= req_addr;
                     ar_len   <= req_len;
                     ar_valid <= 1'b1;
                     state    <= RADDR;
                  end
               end
            end

            RADDR: begin
               if (bus.io_master_arready) begin
                  ar_valid <= 1'b0;
                  r_ready  <= 1'b1;
                  beat_cnt <= 8'd0;
                  state    <= RDATA;
               end
            end

            RDATA: begin
               if (bus.io_master_rvalid) begin
                  rsp_valid <= 1'b1;
                  rsp_data  <= bus.io_master_rdata;
                  // Flag a length disagreement on the closing beat only.
                  rsp_err   <= (bus.io_master_rresp != 2'b00) |
                               (r_final & (bus.io_master_rlast != cnt_hit));
                  beat_cnt  <= beat_cnt + 8'd1;
                  if (r_final) begin
                     rsp_last <= 1'b1;
                     r_ready  <= 1'b0;
                     state    <= IDLE;
                  end
               end
            end

            WREQ: begin
               if (aw_hs) begin
                  aw_valid <= 1'b0;
                  aw_done  <= 1'b1;
               end
               if (w_hs) begin
                  w_valid <= 1'b0;
                  w_done  <= 1'b1;
               end
               // Handshakes may land in either order or together.
               if ((aw_done | aw_hs) && (w_done | w_hs)) begin
                  aw_done <= 1'b0;
                  w_done  <= 1'b0;
                  b_ready <= 1'b1;
                  state   <= WRESP;
               end
            end

            WRESP: begin
               if (bus.io_master_bvalid) begin
                  b_ready   <= 1'b0;
                  rsp_valid <= 1'b1;
                  rsp_last  <= 1'b1;
                  rsp_err   <= (bus.io_master_bresp != 2'b00);
                  state     <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
